// File: rtl/multiword_add_ctrl_pkg.sv
// add_ctrl_pkg: FSM state type and slice-counter width helper for multiword_add_ctrl
package add_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} add_state_t;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multiword_add_ctrl_sumador.sv
// sumadorNbits: N-bit ripple-carry adder used as the per-slice datapath
module sumadorNbits #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] s,
  output logic         c_out
);
  logic [N:0] c;
  assign c[0] = c_in;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign c_out = c[N];
endmodule

// File: rtl/multiword_add_ctrl.sv
// multiword_add_ctrl: adds W=N*SLICES-bit operands one N-bit slice per cycle on a shared adder
// Optional subtraction via macro ADD_CTRL_SUBTRACT_EN (adds sub_in port).
module multiword_add_ctrl
  import add_ctrl_pkg::*;
#(
  parameter int N      = 4,
  parameter int SLICES = 4,
  localparam int W     = N * SLICES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         c_in,
`ifdef ADD_CTRL_SUBTRACT_EN
  input  logic         sub_in,
`endif
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic         ovf,
  output logic         busy
);
  localparam int KW = cnt_w(SLICES);
  localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

  add_state_t    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          fin_q, fin_d, carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, result_q, result_d;
  logic [N-1:0]  sum;
  logic          sum_c;

  sumadorNbits #(.N(N)) u_add (
    .a     (a_q[int'(k_q)*N +: N]),
    .b     (b_q[int'(k_q)*N +: N]),
    .c_in  (carry_q),
    .s     (sum),
    .c_out (sum_c)
  );

  // fin_q marks the extra RUN cycle that commits c_out/ovf after the last slice
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    fin_d    = fin_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: if (start_valid) begin
        a_d      = a_in;
`ifdef ADD_CTRL_SUBTRACT_EN
        b_d      = sub_in ? ~b_in : b_in;
        carry_d  = sub_in | c_in;
`else
        b_d      = b_in;
        carry_d  = c_in;
`endif
        result_d = '0;
        c_out_d  = 1'b0;
        ovf_d    = 1'b0;
        k_d      = '0;
        fin_d    = 1'b0;
        state_d  = ST_RUN;
      end
      ST_RUN: if (fin_q) begin
        c_out_d = carry_q;
        ovf_d   = (a_q[W-1] == b_q[W-1]) && (result_q[W-1] != a_q[W-1]);
        state_d = ST_DONE;
      end else begin
        result_d[int'(k_q)*N +: N] = sum;
        carry_d = sum_c;
        k_d     = k_q + 1'b1;
        fin_d   = (k_q == K_LAST);
      end
      ST_DONE: state_d = res_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      fin_q    <= 1'b0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      fin_q    <= fin_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign start_ready = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign result      = result_q;
  assign c_out       = c_out_q;
  assign ovf         = ovf_q;
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// tb_multiword_add_ctrl: directed vector bench for multiword_add_ctrl (W=16 and SLICES=1 instances)
module tb_multiword_add_ctrl;
  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] res;
    logic        co, ov;
  } vec_t;

  logic        clk = 0, rst_n = 0;
  logic        start_valid = 0, res_ready = 0, c_in = 0, sub_in = 0;
  logic [15:0] a_in = 0, b_in = 0;
  logic        start_ready, res_valid, c_out, ovf, busy;
  logic [15:0] result;
  logic        s1_sv = 0, s1_rr = 0, s1_cin = 0, s1_sr, s1_rv, s1_co, s1_ov, s1_busy;
  logic [3:0]  s1_a = 0, s1_b = 0, s1_res;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  multiword_add_ctrl #(.N(4), .SLICES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
`ifdef ADD_CTRL_SUBTRACT_EN
    .sub_in(sub_in),
`endif
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .c_out(c_out), .ovf(ovf), .busy(busy)
  );

  multiword_add_ctrl #(.N(4), .SLICES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(s1_sv), .start_ready(s1_sr),
    .a_in(s1_a), .b_in(s1_b), .c_in(s1_cin),
`ifdef ADD_CTRL_SUBTRACT_EN
    .sub_in(1'b0),
`endif
    .res_valid(s1_rv), .res_ready(s1_rr), .result(s1_res),
    .c_out(s1_co), .ovf(s1_ov), .busy(s1_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, output int lat);
    a_in = a; b_in = b; c_in = cin; sub_in = sub; start_valid = 1;
    @(posedge clk); #1;
    start_valid = 0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (res_valid) break;
    end
  endtask

  task automatic ack();
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
  endtask

  task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic cin, output int lat);
    s1_a = a; s1_b = b; s1_cin = cin; s1_sv = 1;
    @(posedge clk); #1;
    s1_sv = 0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (s1_rv) break;
    end
  endtask

  vec_t vecs[10];
  int   nv, lat;

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0};
    vecs[1] = '{16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1};
    vecs[2] = '{16'h1234, 16'h1111, 1, 0, 16'h2346, 0, 0};
    vecs[3] = '{16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1};
    vecs[4] = '{16'h0000, 16'h0000, 1, 0, 16'h0001, 0, 0};
    vecs[5] = '{16'h0F0F, 16'hF0F0, 1, 0, 16'h0000, 1, 0};
    vecs[6] = '{16'hA5A5, 16'h5A5A, 0, 0, 16'hFFFF, 0, 0};
    vecs[7] = '{16'h8000, 16'hFFFF, 0, 0, 16'h7FFF, 1, 1};
    nv = 8;
`ifdef ADD_CTRL_SUBTRACT_EN
    vecs[8] = '{16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0};
    vecs[9] = '{16'h0007, 16'h0005, 0, 1, 16'h0002, 1, 0};
    nv = 10;
`endif
    #12;
    check("rst_result", result, 0);
    check("rst_c_out", c_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_start_ready", start_ready, 1);
    rst_n = 1;
    @(posedge clk); #1;

    for (int i = 0; i < nv; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
      check($sformatf("vec%0d_latency", i), lat, 5);
      check($sformatf("vec%0d_result", i), result, {16'h0, vecs[i].res});
      check($sformatf("vec%0d_c_out", i), c_out, {31'h0, vecs[i].co});
      check($sformatf("vec%0d_ovf", i), ovf, {31'h0, vecs[i].ov});
      ack();
      check($sformatf("vec%0d_idle", i), {start_ready, busy, res_valid}, 3'b100);
    end

    // result held through a 3-cycle stall while a stray request is presented
    run_op(16'h1234, 16'h1111, 1, 0, lat);
    a_in = 16'hFFFF; b_in = 16'hFFFF; start_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d_res_valid", i), res_valid, 1);
      check($sformatf("stall%0d_result", i), result, 16'h2346);
      check($sformatf("stall%0d_start_ready", i), start_ready, 0);
    end
    start_valid = 0;
    ack();
    check("stall_after_busy", busy, 0);
    check("stall_after_result", result, 16'h2346);

    // async reset during slice 2
    a_in = 16'h1234; b_in = 16'h1111; c_in = 1; sub_in = 0; start_valid = 1;
    @(posedge clk); #1;
    start_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_partial", result, 16'h0046);
    check("mid_res_valid", res_valid, 0);
    check("mid_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    check("mid_rst_result", result, 0);
    check("mid_rst_flags", {res_valid, busy, start_ready, c_out, ovf}, 5'b00100);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
    run_op(16'h7FFF, 16'h0001, 0, 0, lat);
    check("post_rst_latency", lat, 5);
    check("post_rst_result", result, 16'h8000);
    check("post_rst_flags", {c_out, ovf}, 2'b01);
    ack();

    // single-slice instance
    run1(4'hF, 4'h1, 0, lat);
    check("s1_latency", lat, 2);
    check("s1_result", s1_res, 0);
    check("s1_c_out", s1_co, 1);
    check("s1_ovf", s1_ov, 0);
    s1_rr = 1; @(posedge clk); #1; s1_rr = 0;
    run1(4'h7, 4'h1, 0, lat);
    check("s1b_result", s1_res, 4'h8);
    check("s1b_flags", {s1_co, s1_ov}, 2'b01);
    s1_rr = 1; @(posedge clk); #1; s1_rr = 0;
    check("s1_idle", s1_sr, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
